uart_tx_engine: RTL and testbench

Byte-oriented UART transmit engine that sits directly downstream of the APB UART slave. It accepts bytes on a single-cycle `transmit` strobe, buffers them in a small synchronous FIFO, and serialises them 8N1 onto `tx` at a fixed baud divisor. `tx_fifo_full` provides back-pressure, which the APB side uses to hold off `PREADY`. `busy` reports that bytes are still queued or on the line.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 77 +++++++
 rtl/uart_tx_engine.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART engines: serialiser state encodings and
// frame constants. Imported by uart_tx_engine (and a future RX engine).
// Optional feature macro: VMICRO16_UART_TX_PARITY_EN (the PARITY encoding is
// always declared; only the TX engine decides whether it is ever entered).
// Ports: none (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_PARITY = 3'd3,
    UART_TX_STOP   = 3'd4
  } uart_tx_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Small single-clock FIFO used as the UART byte buffer. Pushes while full and
// pops while empty are ignored. Full/empty are decoded from the registered
// count, so a push that coincides with a pop while full is still rejected.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   push   in   write din this cycle (ignored when full)
//   pop    in   advance read pointer this cycle (ignored when empty)
//   din    in   WIDTH  write data
//   dout   out  WIDTH  data at the read pointer (valid when not empty)
//   count  out  $clog2(DEPTH)+1  current occupancy
//   full   out  count == DEPTH
//   empty  out  count == 0
// DEPTH must be a power of two (pointers wrap by natural overflow).
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// Byte-oriented UART transmitter: bytes strobed in on 'transmit' are queued in
// a uart_sync_fifo and serialised LSB first (start, 8 data, [parity], stop)
// onto a registered 'tx' line at CLKS_PER_BIT clocks per bit. Back-to-back
// bytes are sent with no idle gap between stop and the next start bit.
// Optional feature macro: VMICRO16_UART_TX_PARITY_EN -- when defined, an even
// parity bit (XOR of the data bits) is sent between bit 7 and the stop bit.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low reset (aborts any frame)
//   tx_byte        in   8  byte to enqueue
//   transmit       in   enqueue strobe (dropped while tx_fifo_full)
//   tx_fifo_full   out  FIFO holds FIFO_DEPTH entries
//   tx_fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   busy           out  FIFO non-empty or serialiser not idle
//   tx             out  serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_byte,
  input  logic                          transmit,
  output logic                          tx_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
  output logic                          busy,
  output logic                          tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_e state, state_next;
  logic [BW-1:0]  baud_cnt, baud_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tx_reg, tx_next;
  logic           fifo_pop;
  logic           fifo_empty;
  logic [7:0]     fifo_dout;
  logic           bit_done;
`ifdef VMICRO16_UART_TX_PARITY_EN
  logic           parity_reg, parity_next;
`endif

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (transmit),
    .pop   (fifo_pop),
    .din   (tx_byte),
    .dout  (fifo_dout),
    .count (tx_fifo_count),
    .full  (tx_fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (baud_cnt == BAUD_LAST);
  assign busy     = !fifo_empty || (state != UART_TX_IDLE);
  assign tx       = tx_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= UART_TX_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      tx_reg     <= UART_IDLE_LEVEL;
`ifdef VMICRO16_UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      tx_reg     <= tx_next;
`ifdef VMICRO16_UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Next-state logic. tx is registered, so each branch sets the level the
  // line takes for the bit period that starts on the coming edge. Loading a
  // byte (from IDLE or at the end of STOP) pops the FIFO and drives the start
  // bit on the same edge.
  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    fifo_pop     = 1'b0;
`ifdef VMICRO16_UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state)
      UART_TX_IDLE: begin
        baud_next = '0;
        tx_next   = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
`ifdef VMICRO16_UART_TX_PARITY_EN
          parity_next = ^fifo_dout;
`endif
          tx_next    = 1'b0;
          state_next = UART_TX_START;
        end
      end
      UART_TX_START: begin
        if (bit_done) begin
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = UART_TX_DATA;
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end
      UART_TX_DATA: begin
        if (bit_done) begin
          baud_next = '0;
          if (bit_idx == LAST_BIT) begin
`ifdef VMICRO16_UART_TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = UART_TX_PARITY;
`else
            tx_next    = UART_IDLE_LEVEL;
            state_next = UART_TX_STOP;
`endif
          end else begin
            // The next data bit is bit 1 of the unshifted register.
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end
`ifdef VMICRO16_UART_TX_PARITY_EN
      UART_TX_PARITY: begin
        if (bit_done) begin
          baud_next  = '0;
          tx_next    = UART_IDLE_LEVEL;
          state_next = UART_TX_STOP;
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end
`endif
      UART_TX_STOP: begin
        if (bit_done) begin
          baud_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_dout;
`ifdef VMICRO16_UART_TX_PARITY_EN
            parity_next = ^fifo_dout;
`endif
            tx_next    = 1'b0;
            state_next = UART_TX_START;
          end else begin
            tx_next    = UART_IDLE_LEVEL;
            state_next = UART_TX_IDLE;
          end
        end else begin
          baud_next = baud_cnt + BAUD_ONE;
        end
      end
      default: begin
        baud_next  = '0;
        tx_next    = UART_IDLE_LEVEL;
        state_next = UART_TX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Self-checking bench for uart_tx_engine (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A frame-level reference model (byte queue + position inside the current
// frame) predicts tx, busy, tx_fifo_count and tx_fifo_full every cycle.
// Honours VMICRO16_UART_TX_PARITY_EN (11-bit frames with even parity).
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef VMICRO16_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       tx_fifo_full;
  logic [3:0] tx_fifo_count;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0] model_q [$];
  bit         active = 1'b0;
  int         frame_pos = 0;
  logic [7:0] cur_byte = 8'h00;

  uart_tx_engine #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_byte       (tx_byte),
    .transmit      (transmit),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_count (tx_fifo_count),
    .busy          (busy),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  // Line level for bit period idx of a frame carrying byte b.
  function automatic logic frame_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef VMICRO16_UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check_value(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic check_output();
    logic exp_tx;
    exp_tx = active ? frame_bit(cur_byte, frame_pos / CPB) : 1'b1;
    check_value("tx", 32'(tx), 32'(exp_tx));
    check_value("busy", 32'(busy), 32'(active || (model_q.size() != 0)));
    check_value("count", 32'(tx_fifo_count), 32'(model_q.size()));
    check_value("full", 32'(tx_fifo_full), 32'(model_q.size() == DEPTH));
  endtask

  // Advance the model by one clock edge, clock the DUT, then check.
  // Acceptance uses the occupancy before the edge, so a push coinciding with
  // a pop while full is refused.
  task automatic step();
    bit accept;
    accept = transmit && (model_q.size() < DEPTH);
    if (active) begin
      frame_pos++;
      if (frame_pos == FL) begin
        if (model_q.size() != 0) begin
          cur_byte  = model_q.pop_front();
          frame_pos = 0;
        end else begin
          active = 1'b0;
        end
      end
    end else if (model_q.size() != 0) begin
      cur_byte  = model_q.pop_front();
      active    = 1'b1;
      frame_pos = 0;
    end
    if (accept) model_q.push_back(tx_byte);
    @(posedge clk);
    @(negedge clk);
    cycle++;
    check_output();
  endtask

  task automatic apply_stimulus(logic t, logic [7:0] b);
    transmit = t;
    tx_byte  = b;
    step();
    transmit = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((active || model_q.size() != 0) && guard < 20 * FL) begin
      apply_stimulus(1'b0, 8'h00);
      guard++;
    end
    check_value("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    transmit = 1'b0;
    tx_byte  = 8'h00;
    reset    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_value("reset_tx", 32'(tx), 32'd1);
    check_value("reset_busy", 32'(busy), 32'd0);
    check_value("reset_full", 32'(tx_fifo_full), 32'd0);
    check_value("reset_count", 32'(tx_fifo_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single byte: tx falls on the edge after transmit is sampled.
    $display("[TB] single byte 0x55");
    apply_stimulus(1'b1, 8'h55);
    check_value("t1_count_after_push", 32'(tx_fifo_count), 32'd1);
    apply_stimulus(1'b0, 8'h00);
    check_value("t1_start_bit", 32'(tx), 32'd0);
    drain();

    // Two bytes on consecutive cycles: the second push lands on the edge
    // that pops the first, so the count stays at 1; frames are contiguous.
    $display("[TB] back-to-back 0xA5 0x3C");
    apply_stimulus(1'b1, 8'hA5);
    apply_stimulus(1'b1, 8'h3C);
    check_value("t2_count_push_pop", 32'(tx_fifo_count), 32'd1);
    drain();

    // Fill while the serialiser is busy; 9th byte dropped, then a push that
    // coincides with the pop at the end of the frame is also dropped.
    $display("[TB] fill to full");
    apply_stimulus(1'b1, 8'h81);
    apply_stimulus(1'b0, 8'h00);
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 8'(8'h10 + i));
    check_value("t3_full", 32'(tx_fifo_full), 32'd1);
    check_value("t3_count_full", 32'(tx_fifo_count), 32'd8);
    for (int g = 0; g < FL && frame_pos != FL - 1; g++) apply_stimulus(1'b0, 8'h00);
    apply_stimulus(1'b1, 8'hEE);
    check_value("t3_push_during_pop", 32'(tx_fifo_count), 32'd7);
    drain();

    // Reset in the middle of DATA of 0xFF with two bytes still queued.
    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 8'hFF);
    apply_stimulus(1'b1, 8'h12);
    apply_stimulus(1'b1, 8'h34);
    for (int g = 0; g < FL && frame_pos != 2 * CPB + 1; g++) apply_stimulus(1'b0, 8'h00);
    reset = 1'b0;
    #1;
    model_q.delete();
    active = 1'b0;
    check_value("t4_reset_tx", 32'(tx), 32'd1);
    check_value("t4_reset_busy", 32'(busy), 32'd0);
    check_value("t4_reset_count", 32'(tx_fifo_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b1, 8'h07);
    apply_stimulus(1'b1, 8'h03);
    drain();

    // Random traffic, including bursts long enough to hit full.
    $display("[TB] random traffic");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 60; i++) apply_stimulus($urandom_range(0, 2) == 0, 8'($urandom));
      for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 8'($urandom));
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
